// File: rtl/jbi_ncio_prtq_crdt_if.sv
// PRTQ credit scheduler bus: PRQQ read request/grant, CSR controls, return credits and status.
interface jbi_ncio_prtq_crdt_if #(
   parameter int CNT_W = 5
);
   logic [3:0]       csr_jbi_config2_max_pio;
   logic             csr_prtq_flush;
   logic             prqq_rd_req;
   logic             prtq_decr_rd_pend_cnt;
   logic             ncio_rd_gnt;
   logic [CNT_W-1:0] ncio_rd_pend_cnt;
   logic             ncio_prtq_no_crdt;
   logic             ncio_rd_pend_none;
   logic             ncio_flush_done;
   logic             ncio_rtn_timeout;
   logic             ncio_crdt_underflow;

   modport master (
      output csr_jbi_config2_max_pio, csr_prtq_flush, prqq_rd_req, prtq_decr_rd_pend_cnt,
      input  ncio_rd_gnt, ncio_rd_pend_cnt, ncio_prtq_no_crdt, ncio_rd_pend_none,
             ncio_flush_done, ncio_rtn_timeout, ncio_crdt_underflow
   );

   modport slave (
      input  csr_jbi_config2_max_pio, csr_prtq_flush, prqq_rd_req, prtq_decr_rd_pend_cnt,
      output ncio_rd_gnt, ncio_rd_pend_cnt, ncio_prtq_no_crdt, ncio_rd_pend_none,
             ncio_flush_done, ncio_rtn_timeout, ncio_crdt_underflow
   );
endinterface

// File: rtl/jbi_ncio_prtq_crdt.sv
// PRTQ credit scheduler: grants PIO reads only while a PRTQ entry is free, with
// flush/drain sequencing, a return-timeout watchdog and a sticky underflow flag.
//
// state | meaning
// RUN   | normal operation, grants allowed
// DRAIN | flush requested, grants blocked until all reads return
// DONE  | drain complete, flush_done pulses for one cycle
module jbi_ncio_prtq_crdt #(
   parameter int DEPTH    = 16,
   parameter int CNT_W    = 5,
   parameter int STALL_TO = 1024,
   parameter int TO_W     = 10
) (
   input logic                clk,
   input logic                rst_l,
   jbi_ncio_prtq_crdt_if.slave ncio
);
   localparam logic [1:0]       ST_RUN   = 2'b00;
   localparam logic [1:0]       ST_DRAIN = 2'b01;
   localparam logic [1:0]       ST_DONE  = 2'b10;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(STALL_TO - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] r_pend;
   logic [CNT_W-1:0] w_pend_nxt;
   logic [CNT_W-1:0] w_max;
   logic [CNT_W-1:0] w_limit;
   logic [TO_W-1:0]  r_to_cnt;
   logic [TO_W-1:0]  w_to_nxt;
   logic             r_uf;
   logic             w_ret;
   logic             w_gnt;
   logic             w_uf_evt;
   logic             w_stall;
   logic             w_to;

   assign w_ret    = ncio.prtq_decr_rd_pend_cnt;
   assign w_max    = CNT_W'(ncio.csr_jbi_config2_max_pio);
   assign w_limit  = (w_max == '0) ? DEPTH_C : ((w_max > DEPTH_C) ? DEPTH_C : w_max);
   // Grant is held low while reset is asserted so nothing issues into a resetting queue.
   assign w_gnt    = rst_l & ncio.prqq_rd_req & (r_state == ST_RUN) & (r_pend < w_limit);
   assign w_uf_evt = w_ret & (r_pend == '0);

   always_comb begin
      w_pend_nxt = r_pend;
      if (!w_uf_evt) begin
         if (w_gnt && !w_ret) begin
            w_pend_nxt = r_pend + 1'b1;
         end else if (!w_gnt && w_ret) begin
            w_pend_nxt = r_pend - 1'b1;
         end
      end
   end

   // DRAIN looks at the next count so a return in the same cycle finishes the drain.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:   if (ncio.csr_prtq_flush) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_pend_nxt == '0) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

   assign w_stall  = (r_pend != '0) & ~w_ret;
   assign w_to     = w_stall & (r_to_cnt == TO_LAST);
   assign w_to_nxt = (!w_stall || w_to) ? '0 : r_to_cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state  <= ST_RUN;
         r_pend   <= '0;
         r_to_cnt <= '0;
         r_uf     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pend   <= w_pend_nxt;
         r_to_cnt <= w_to_nxt;
         if (w_uf_evt) begin
            r_uf <= 1'b1;
         end
      end
   end

   assign ncio.ncio_rd_gnt         = w_gnt;
   assign ncio.ncio_rd_pend_cnt    = r_pend;
   assign ncio.ncio_prtq_no_crdt   = (r_pend >= w_limit);
   assign ncio.ncio_rd_pend_none   = (r_pend == '0);
   assign ncio.ncio_flush_done     = (r_state == ST_DONE);
   assign ncio.ncio_rtn_timeout    = w_to;
   assign ncio.ncio_crdt_underflow = r_uf;
endmodule

// File: tb/tb_jbi_ncio_prtq_crdt.sv
// Bench for the PRTQ credit scheduler: directed scenarios plus random traffic
// checked every cycle against a credit-count reference model.
module tb_jbi_ncio_prtq_crdt;
   localparam int DEPTH    = 16;
   localparam int CNT_W    = 5;
   localparam int STALL_TO = 8;
   localparam int TO_W     = 3;

   logic clk   = 1'b0;
   logic rst_l = 1'b0;
   always #5 clk = ~clk;

   jbi_ncio_prtq_crdt_if #(.CNT_W(CNT_W)) bus ();

   jbi_ncio_prtq_crdt #(
      .DEPTH(DEPTH), .CNT_W(CNT_W), .STALL_TO(STALL_TO), .TO_W(TO_W)
   ) dut (
      .clk(clk), .rst_l(rst_l), .ncio(bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: reads in flight, mode (0 run, 1 drain, 2 done), stalled-cycle run length.
   int m_pend;
   int m_mode;
   int m_run;
   bit m_uf;
   bit e_gnt, e_nocrdt, e_none, e_done, e_to;

   function automatic int limit_of(int mp);
      if (mp == 0) return DEPTH;
      return (mp < DEPTH) ? mp : DEPTH;
   endfunction

   function automatic logic [10:0] obs();
      return {bus.ncio_rd_gnt, bus.ncio_rd_pend_cnt, bus.ncio_prtq_no_crdt, bus.ncio_rd_pend_none,
              bus.ncio_flush_done, bus.ncio_rtn_timeout, bus.ncio_crdt_underflow};
   endfunction

   function automatic logic [10:0] expv();
      return {e_gnt, CNT_W'(m_pend), e_nocrdt, e_none, e_done, e_to, m_uf};
   endfunction

   task automatic model_reset();
      m_pend = 0; m_mode = 0; m_run = 0; m_uf = 1'b0;
   endtask

   task automatic drive(input bit req, input bit ret, input bit fl);
      bus.prqq_rd_req           = req;
      bus.prtq_decr_rd_pend_cnt = ret;
      bus.csr_prtq_flush        = fl;
   endtask

   // Wait for the sampling edge and derive this cycle's expected outputs.
   task automatic eval();
      int lim;
      @(negedge clk);
      lim      = limit_of(int'(bus.csr_jbi_config2_max_pio));
      e_gnt    = bus.prqq_rd_req && (m_mode == 0) && (m_pend < lim);
      e_nocrdt = (m_pend >= lim);
      e_none   = (m_pend == 0);
      e_done   = (m_mode == 2);
      e_to     = (m_pend != 0) && !bus.prtq_decr_rd_pend_cnt && (((m_run + 1) % STALL_TO) == 0);
   endtask

   task automatic adv();
      bit ret, fl;
      ret = bus.prtq_decr_rd_pend_cnt;
      fl  = bus.csr_prtq_flush;
      @(posedge clk);
      if (m_pend != 0 && !ret) m_run++; else m_run = 0;
      if (ret && m_pend == 0) m_uf = 1'b1;
      else m_pend = m_pend + int'(e_gnt) - int'(ret);
      case (m_mode)
         0:       if (fl) m_mode = 1;
         1:       if (m_pend == 0) m_mode = 2;
         default: m_mode = 0;
      endcase
      #1;
   endtask

   task automatic test_reset();
      rst_l = 1'b0;
      bus.csr_jbi_config2_max_pio = 4'd0;
      drive(1'b1, 1'b0, 1'b0);
      model_reset();
      #3;
      checks++;
      if (obs() !== {1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_outputs got=%b expected=%b", obs(), {1'b0, 5'd0, 4'b0100, 1'b0});
      end
      @(posedge clk); #1;
      rst_l = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_fill();
      int n_gnt = 0;
      bus.csr_jbi_config2_max_pio = 4'd0;
      drive(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 20; c++) begin
         eval();
         checks++;
         if (obs() !== expv()) begin
            failures++;
            $display("FAIL fill_cycle c=%0d got=%b expected=%b", c, obs(), expv());
         end
         if (bus.ncio_rd_gnt === 1'b1) n_gnt++;
         adv();
      end
      drive(1'b0, 1'b0, 1'b0);
      eval();
      checks++;
      if (n_gnt != DEPTH) begin
         failures++;
         $display("FAIL fill_gnt_count got=%0d expected=%0d", n_gnt, DEPTH);
      end
      checks++;
      if (bus.ncio_rd_pend_cnt !== 5'd16 || bus.ncio_prtq_no_crdt !== 1'b1) begin
         failures++;
         $display("FAIL fill_full got pend=%0d no_crdt=%b expected pend=16 no_crdt=1",
                  bus.ncio_rd_pend_cnt, bus.ncio_prtq_no_crdt);
      end
      adv();
      for (int c = 0; c < 20 && m_pend > 0; c++) begin
         drive(1'b0, 1'b1, 1'b0);
         eval();
         checks++;
         if (obs() !== expv()) begin
            failures++;
            $display("FAIL fill_drain c=%0d got=%b expected=%b", c, obs(), expv());
         end
         adv();
      end
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_limit();
      int n_gnt = 0;
      bus.csr_jbi_config2_max_pio = 4'd4;
      drive(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 6; c++) begin
         eval();
         checks++;
         if (obs() !== expv()) begin
            failures++;
            $display("FAIL limit_cycle c=%0d got=%b expected=%b", c, obs(), expv());
         end
         if (bus.ncio_rd_gnt === 1'b1) n_gnt++;
         adv();
      end
      checks++;
      if (n_gnt != 4) begin
         failures++;
         $display("FAIL limit_gnt_count got=%0d expected=4", n_gnt);
      end
      drive(1'b1, 1'b1, 1'b0);
      eval();
      checks++;
      if (bus.ncio_rd_gnt !== 1'b0) begin
         failures++;
         $display("FAIL limit_ret_cycle_gnt got=%b expected=0", bus.ncio_rd_gnt);
      end
      adv();
      drive(1'b1, 1'b0, 1'b0);
      eval();
      checks++;
      if (bus.ncio_rd_gnt !== 1'b1) begin
         failures++;
         $display("FAIL limit_regrant got=%b expected=1", bus.ncio_rd_gnt);
      end
      adv();
      drive(1'b0, 1'b0, 1'b0);
      eval();
      checks++;
      if (bus.ncio_rd_pend_cnt !== 5'd4) begin
         failures++;
         $display("FAIL limit_pend got=%0d expected=4", bus.ncio_rd_pend_cnt);
      end
      adv();
      for (int c = 0; c < 10 && m_pend > 0; c++) begin
         drive(1'b0, 1'b1, 1'b0);
         eval();
         adv();
      end
      drive(1'b0, 1'b0, 1'b0);
      bus.csr_jbi_config2_max_pio = 4'd0;
   endtask

   task automatic test_same_cycle();
      drive(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin eval(); adv(); end
      drive(1'b1, 1'b1, 1'b0);
      eval();
      checks++;
      if (obs() !== expv()) begin
         failures++;
         $display("FAIL same_cycle_edge got=%b expected=%b", obs(), expv());
      end
      adv();
      drive(1'b0, 1'b0, 1'b0);
      eval();
      checks++;
      if (bus.ncio_rd_pend_cnt !== 5'd3 || bus.ncio_crdt_underflow !== 1'b0) begin
         failures++;
         $display("FAIL same_cycle_pend got pend=%0d uf=%b expected pend=3 uf=0",
                  bus.ncio_rd_pend_cnt, bus.ncio_crdt_underflow);
      end
      adv();
      for (int c = 0; c < 10 && m_pend > 0; c++) begin
         drive(1'b0, 1'b1, 1'b0);
         eval();
         adv();
      end
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_flush();
      int  n_done = 0;
      bit  resumed = 1'b0;
      drive(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 2; c++) begin eval(); adv(); end
      drive(1'b1, 1'b0, 1'b1);
      eval();
      adv();
      drive(1'b1, 1'b0, 1'b0);
      eval();
      checks++;
      if (bus.ncio_rd_gnt !== 1'b0) begin
         failures++;
         $display("FAIL flush_gnt_blocked got=%b expected=0", bus.ncio_rd_gnt);
      end
      adv();
      for (int c = 0; c < 20 && !resumed; c++) begin
         drive(1'b1, m_pend > 0, 1'b0);
         eval();
         checks++;
         if (obs() !== expv()) begin
            failures++;
            $display("FAIL flush_cycle c=%0d got=%b expected=%b", c, obs(), expv());
         end
         if (bus.ncio_flush_done === 1'b1) n_done++;
         else if (n_done > 0) begin
            resumed = 1'b1;
            checks++;
            if (bus.ncio_rd_gnt !== 1'b1) begin
               failures++;
               $display("FAIL flush_resume_gnt got=%b expected=1", bus.ncio_rd_gnt);
            end
         end
         adv();
      end
      checks++;
      if (n_done != 1 || !resumed) begin
         failures++;
         $display("FAIL flush_done_pulse got pulses=%0d resumed=%b expected pulses=1 resumed=1",
                  n_done, resumed);
      end
      for (int c = 0; c < 10 && m_pend > 0; c++) begin
         drive(1'b0, 1'b1, 1'b0);
         eval();
         adv();
      end
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_watchdog();
      int first = 0, second = 0, n_to = 0;
      drive(1'b1, 1'b0, 1'b0);
      eval(); adv();
      drive(1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 20; c++) begin
         eval();
         checks++;
         if (obs() !== expv()) begin
            failures++;
            $display("FAIL watchdog_cycle c=%0d got=%b expected=%b", c, obs(), expv());
         end
         if (bus.ncio_rtn_timeout === 1'b1) begin
            n_to++;
            if (n_to == 1) first = c;
            if (n_to == 2) second = c;
         end
         adv();
      end
      checks++;
      if (n_to != 2 || first != 8 || second != 16) begin
         failures++;
         $display("FAIL watchdog_pulses got n=%0d at %0d,%0d expected n=2 at 8,16", n_to, first, second);
      end
      drive(1'b0, 1'b1, 1'b0);
      eval(); adv();
      drive(1'b0, 1'b0, 1'b0);
      n_to = 0;
      for (int c = 0; c < 12; c++) begin
         eval();
         if (bus.ncio_rtn_timeout === 1'b1) n_to++;
         adv();
      end
      checks++;
      if (n_to != 0 || bus.ncio_rd_pend_cnt !== 5'd0) begin
         failures++;
         $display("FAIL watchdog_quiet got pulses=%0d pend=%0d expected pulses=0 pend=0",
                  n_to, bus.ncio_rd_pend_cnt);
      end
   endtask

   task automatic test_random();
      bit req = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (c % 50 == 0) bus.csr_jbi_config2_max_pio = 4'($urandom_range(0, 15));
         if (e_gnt) req = 1'b0;
         else if (!req) req = ($urandom_range(0, 2) != 0);
         drive(req, (m_pend > 0) && ($urandom_range(0, 2) == 0), $urandom_range(0, 40) == 0);
         eval();
         checks++;
         if (obs() !== expv()) begin
            failures++;
            $display("FAIL random_cycle c=%0d got=%b expected=%b", c, obs(), expv());
         end
         adv();
      end
      for (int c = 0; c < 40 && (m_pend > 0 || m_mode != 0); c++) begin
         drive(1'b0, m_pend > 0, 1'b0);
         eval();
         adv();
      end
      drive(1'b0, 1'b0, 1'b0);
      bus.csr_jbi_config2_max_pio = 4'd0;
   endtask

   task automatic test_underflow_reset();
      drive(1'b0, 1'b1, 1'b0);
      eval();
      adv();
      drive(1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         eval();
         checks++;
         if (bus.ncio_crdt_underflow !== 1'b1 || bus.ncio_rd_pend_cnt !== 5'd0) begin
            failures++;
            $display("FAIL underflow_sticky c=%0d got uf=%b pend=%0d expected uf=1 pend=0",
                     c, bus.ncio_crdt_underflow, bus.ncio_rd_pend_cnt);
         end
         adv();
      end
      drive(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 2; c++) begin eval(); adv(); end
      drive(1'b1, 1'b0, 1'b1);
      eval(); adv();
      drive(1'b1, 1'b0, 1'b0);
      #2;
      rst_l = 1'b0;
      model_reset();
      #1;
      checks++;
      if (obs() !== {1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL midflush_reset got=%b expected=%b", obs(), {1'b0, 5'd0, 4'b0100, 1'b0});
      end
      @(posedge clk); #1;
      rst_l = 1'b1;
      for (int c = 0; c < 3; c++) begin
         eval();
         checks++;
         if (obs() !== expv()) begin
            failures++;
            $display("FAIL post_reset c=%0d got=%b expected=%b", c, obs(), expv());
         end
         adv();
      end
      drive(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fill();
      test_limit();
      test_same_cycle();
      test_flush();
      test_watchdog();
      test_random();
      test_underflow_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
